// File: rtl/riscv_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_scoreboard
//  Purpose  : Per-register write-back scoreboard placed in front of the
//             register file read port. It counts the issued instructions that
//             still owe a write-back to each architectural register. While a
//             source operand is not yet written, or a destination counter is
//             full, it holds issue.
//  Ports    : clk_i, rst_i (async, active-low)
//             issue_valid_i, rs1/rs2_addr_i, rs1/rs2_used_i, rd_addr_i,
//             rd_wen_i        - decoded instruction presented for issue
//             wb_valid_i, wb_addr_i - retiring register write
//             flush_i         - discard all outstanding writes
//             stall_o, issue_fire_o - combinational issue control
//             pending_o, busy_o     - registered per-register pending view
//             wb_err_o        - sticky unmatched write-back flag
//             stall_cnt_o     - saturating stalled-cycle counter
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_scoreboard #(
    parameter int CNT_W  = 2,
    parameter int PERF_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              issue_valid_i,
    input  logic [4:0]        rs1_addr_i,
    input  logic [4:0]        rs2_addr_i,
    input  logic              rs1_used_i,
    input  logic              rs2_used_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              rd_wen_i,
    input  logic              wb_valid_i,
    input  logic [4:0]        wb_addr_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              issue_fire_o,
    output logic [31:0]       pending_o,
    output logic              busy_o,
    output logic              wb_err_o,
    output logic [PERF_W-1:0] stall_cnt_o
);

    localparam logic [CNT_W-1:0]  c_CNT_MAX  = '1;
    localparam logic [PERF_W-1:0] c_PERF_MAX = '1;

    // Counter view indexed by register number. Entry 0 is tied to zero so
    // that x0 never appears pending and never causes a hazard.
    logic [31:0][CNT_W-1:0] w_cnt;
    logic [31:0]            w_nz;
    logic                   w_raw1;
    logic                   w_raw2;
    logic                   w_full;
    logic                   w_stall;
    logic                   w_fire;
    logic                   w_wb_orphan;

    logic                   r_wb_err;
    logic [PERF_W-1:0]      r_stall_cnt;

    assign w_cnt[0] = '0;

    for (genvar gi = 1; gi < 32; gi++) begin : g_cnt
        logic [CNT_W-1:0] r_cnt;
        logic             w_inc;
        logic             w_dec;

        assign w_inc = w_fire & rd_wen_i & (rd_addr_i == 5'(gi));
        // A write-back only retires a write that is actually outstanding.
        assign w_dec = wb_valid_i & (wb_addr_i == 5'(gi)) & (r_cnt != '0);

        // Incrementing past the maximum cannot happen: a full destination
        // stalls issue, so w_inc is never set while r_cnt is at its maximum.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
                r_cnt <= '0;
            end else if (flush_i) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign w_cnt[gi] = r_cnt;
    end

    for (genvar gj = 0; gj < 32; gj++) begin : g_nz
        assign w_nz[gj] = (w_cnt[gj] != '0);
    end

    // Hazards use only registered counters; a write-back in the same cycle
    // does not release a dependent instruction. That instruction issues on
    // the next cycle, in step with the synchronous register-file write.
    assign w_raw1  = rs1_used_i & w_nz[rs1_addr_i];
    assign w_raw2  = rs2_used_i & w_nz[rs2_addr_i];
    assign w_full  = rd_wen_i & (rd_addr_i != 5'd0) & (w_cnt[rd_addr_i] == c_CNT_MAX);
    assign w_stall = issue_valid_i & (w_raw1 | w_raw2 | w_full) & ~flush_i;
    assign w_fire  = issue_valid_i & ~w_stall;

    // A write-back to a non-zero register that has no outstanding write.
    assign w_wb_orphan = wb_valid_i & (wb_addr_i != 5'd0) & ~w_nz[wb_addr_i];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wb_err    <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (w_wb_orphan) begin
                r_wb_err <= 1'b1;
            end
            if (issue_valid_i && w_stall && (r_stall_cnt != c_PERF_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall_o      = w_stall;
    assign issue_fire_o = w_fire;
    assign pending_o    = w_nz;
    assign busy_o       = |w_nz;
    assign wb_err_o     = r_wb_err;
    assign stall_cnt_o  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_riscv_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_scoreboard
//  Purpose  : Self-checking bench for riscv_scoreboard. Stimulus pushes
//             expected observations into a queue; a monitor on the falling
//             edge pops them and compares them against the DUT outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_riscv_scoreboard;

    localparam int K_STALL = 0;
    localparam int K_FIRE  = 1;
    localparam int K_PEND  = 2;
    localparam int K_BUSY  = 3;
    localparam int K_ERR   = 4;
    localparam int K_SCNT  = 5;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] val;
    } chk_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_used_i;
    logic        rs2_used_i;
    logic [4:0]  rd_addr_i;
    logic        rd_wen_i;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic        flush_i;
    logic        stall_o;
    logic        issue_fire_o;
    logic [31:0] pending_o;
    logic        busy_o;
    logic        wb_err_o;
    logic [15:0] stall_cnt_o;

    chk_t        q[$];
    int          total = 0;
    int          bad   = 0;

    riscv_scoreboard #(.CNT_W(2), .PERF_W(16)) u_dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .issue_valid_i (issue_valid_i),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rs1_used_i    (rs1_used_i),
        .rs2_used_i    (rs2_used_i),
        .rd_addr_i     (rd_addr_i),
        .rd_wen_i      (rd_wen_i),
        .wb_valid_i    (wb_valid_i),
        .wb_addr_i     (wb_addr_i),
        .flush_i       (flush_i),
        .stall_o       (stall_o),
        .issue_fire_o  (issue_fire_o),
        .pending_o     (pending_o),
        .busy_o        (busy_o),
        .wb_err_o      (wb_err_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- monitor ----------------
    chk_t        m_e;
    logic [31:0] m_act;
    always @(negedge clk_i) begin
        while (q.size() > 0) begin
            m_e = q.pop_front();
            case (m_e.kind)
                K_STALL: m_act = {31'd0, stall_o};
                K_FIRE:  m_act = {31'd0, issue_fire_o};
                K_PEND:  m_act = pending_o;
                K_BUSY:  m_act = {31'd0, busy_o};
                K_ERR:   m_act = {31'd0, wb_err_o};
                default: m_act = {16'd0, stall_cnt_o};
            endcase
            total++;
            if (m_act !== m_e.val) begin
                bad++;
                $display("FAIL %s: got=0x%08h want=0x%08h", m_e.name, m_act, m_e.val);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic expect_v(input string n, input int k, input logic [31:0] v);
        chk_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        issue_valid_i = 1'b0;
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd0;
        rs1_used_i = 1'b0; rs2_used_i = 1'b0;
        rd_addr_i  = 5'd0; rd_wen_i   = 1'b0;
        wb_valid_i = 1'b0; wb_addr_i  = 5'd0;
        flush_i    = 1'b0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic wen,
                         input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2);
        issue_valid_i = 1'b1;
        rd_addr_i = rd;   rd_wen_i   = wen;
        rs1_addr_i = rs1; rs1_used_i = u1;
        rs2_addr_i = rs2; rs2_used_i = u2;
    endtask

    task automatic wb(input logic v, input logic [4:0] a);
        wb_valid_i = v;
        wb_addr_i  = a;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_i = 1'b0;
        idle();
        step();
        expect_v("reset_pending", K_PEND, 32'd0);
        expect_v("reset_busy",    K_BUSY, 32'd0);
        expect_v("reset_err",     K_ERR,  32'd0);
        expect_v("reset_scnt",    K_SCNT, 32'd0);
        expect_v("reset_nostall", K_STALL, 32'd0);
        step();
        rst_i = 1'b1;
        step();

        // RAW on x5
        issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_v("raw_first_fire", K_FIRE, 32'd1);
        step();
        issue(5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        expect_v("raw_stall_n1", K_STALL, 32'd1);
        expect_v("raw_pend_n1",  K_PEND,  32'h0000_0020);
        step();
        expect_v("raw_stall_n2", K_STALL, 32'd1);
        step();
        wb(1'b1, 5'd5);
        expect_v("raw_stall_wb_nobypass", K_STALL, 32'd1);
        expect_v("raw_scnt_n3", K_SCNT, 32'd2);
        step();
        wb(1'b0, 5'd0);
        expect_v("raw_stall_n4", K_STALL, 32'd0);
        expect_v("raw_fire_n4",  K_FIRE,  32'd1);
        expect_v("raw_pend_n4",  K_PEND,  32'd0);
        expect_v("raw_scnt_n4",  K_SCNT,  32'd3);
        step();

        // x0 destination and unused sources
        idle();
        issue(5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_v("x0_fire", K_FIRE, 32'd1);
        step();
        idle();
        wb(1'b1, 5'd0);
        expect_v("x0_pend", K_PEND, 32'd0);
        expect_v("x0_busy", K_BUSY, 32'd0);
        step();
        idle();
        issue(5'd7, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        expect_v("x0_wb_noerr", K_ERR, 32'd0);
        step();
        issue(5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
        expect_v("unused_rs2_nostall", K_STALL, 32'd0);
        expect_v("x7_pend", K_PEND, 32'h0000_0080);
        expect_v("x7_busy", K_BUSY, 32'd1);
        step();
        issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1);
        expect_v("used_rs2_stall", K_STALL, 32'd1);
        step();
        idle();
        wb(1'b1, 5'd7);
        step();
        idle();
        expect_v("x7_cleared", K_PEND, 32'd0);
        expect_v("scnt_after_x7", K_SCNT, 32'd4);
        step();

        // WAW saturation on x9
        for (int i = 0; i < 3; i++) begin
            issue(5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
            expect_v("waw_fire", K_FIRE, 32'd1);
            step();
        end
        expect_v("waw_full_stall", K_STALL, 32'd1);
        expect_v("waw_pend", K_PEND, 32'h0000_0200);
        step();
        wb(1'b1, 5'd9);
        expect_v("waw_full_wb_stall", K_STALL, 32'd1);
        step();
        wb(1'b0, 5'd0);
        expect_v("waw_fourth_fire", K_FIRE, 32'd1);
        expect_v("waw_still_pend", K_PEND, 32'h0000_0200);
        expect_v("waw_scnt", K_SCNT, 32'd6);
        step();
        idle();
        wb(1'b1, 5'd9);
        step(); step();
        expect_v("waw_pend_last", K_PEND, 32'h0000_0200);
        step();
        idle();
        expect_v("waw_drained", K_PEND, 32'd0);
        expect_v("waw_drained_err", K_ERR, 32'd0);
        step();

        // simultaneous issue and write-back on x4, orphan write-back on x6
        issue(5'd4, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        wb(1'b1, 5'd4);
        expect_v("sim_fire", K_FIRE, 32'd1);
        step();
        idle();
        expect_v("sim_pend_kept", K_PEND, 32'h0000_0010);
        wb(1'b1, 5'd4);
        step();
        wb(1'b1, 5'd6);
        expect_v("sim_pend_cleared", K_PEND, 32'd0);
        step();
        idle();
        expect_v("orphan_err", K_ERR, 32'd1);
        step();
        expect_v("orphan_err_sticky", K_ERR, 32'd1);
        expect_v("orphan_pend", K_PEND, 32'd0);
        step();

        // flush with concurrent issue that would otherwise stall on x2
        issue(5'd2, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        issue(5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        issue(5'd10, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
        flush_i = 1'b1;
        expect_v("flush_pend_before", K_PEND, 32'h0000_0104);
        expect_v("flush_busy_before", K_BUSY, 32'd1);
        expect_v("flush_masks_stall", K_STALL, 32'd0);
        step();
        idle();
        expect_v("flush_pend", K_PEND, 32'd0);
        expect_v("flush_busy", K_BUSY, 32'd0);
        expect_v("flush_scnt", K_SCNT, 32'd6);
        expect_v("flush_err_kept", K_ERR, 32'd1);
        step();

        // asynchronous reset mid-cycle with x3 pending
        issue(5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step();
        idle();
        expect_v("pre_rst_pend", K_PEND, 32'h0000_0008);
        step();
        rst_i = 1'b0;
        expect_v("arst_pend", K_PEND, 32'd0);
        expect_v("arst_busy", K_BUSY, 32'd0);
        expect_v("arst_scnt", K_SCNT, 32'd0);
        expect_v("arst_err",  K_ERR,  32'd0);
        step();
        rst_i = 1'b1;
        step();
        step();

        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got=%0d want=0 unchecked entries", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/riscv_scoreboard.md
# riscv_scoreboard

Register scoreboard sitting directly upstream of the register file read port, between decode and `riscv_regfile`. It tracks, per architectural register, how many issued instructions still owe a write-back and holds issue (`stall_o`) while a source operand or destination slot is not safe. It thereby replaces the per-register wait bits inside the register file with an explicit, counted, flushable scoreboard.

## Interface
- `CNT_W`, default 2: per-register outstanding-write counter width; max outstanding writes per register = 2^CNT_W − 1 (3).
- `PERF_W`, default 16: width of the stall performance counter.

- `clk_i`  in  1  clock. Single clock; all logic on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-low.
- `issue_valid_i`  in  1  decode presents an instruction this cycle.
- `rs1_addr_i` / `rs2_addr_i`  in  5 each  source register addresses.
- `rs1_used_i` / `rs2_used_i`  in  1 each  instruction actually reads that source.
- `rd_addr_i`  in  5  destination address.
- `rd_wen_i`  in  1  instruction writes `rd_addr_i`.
- `wb_valid_i`  in  1  write-back stage retires a write this cycle (same strobe as regfile `RegWEn_i`).
- `wb_addr_i`  in  5  retiring destination address.
- `flush_i`  in  1  pipeline flush; discards all outstanding entries.
- `stall_o`  out  1  issue must be held this cycle (combinational).
- `issue_fire_o`  out  1  `issue_valid_i & ~stall_o`.
- `pending_o`  out  32  bit r = counter[r] ≠ 0 (registered state).
- `busy_o`  out  1  any bit of `pending_o` set.
- `wb_err_o`  out  1  sticky: write-back seen for a register with counter 0.
- `stall_cnt_o`  out  PERF_W  saturating count of cycles with `issue_valid_i & stall_o`.

## Operation
- State: 32 counters of CNT_W bits (counter[0] hardwired 0), `wb_err` flag, stall counter.
- Hazard (combinational, from registered counters only, no same-cycle write-back bypass):
  - raw1 = `rs1_used_i` & rs1≠0 & counter[rs1]≠0; raw2 likewise for rs2.
  - full = `rd_wen_i` & rd≠0 & counter[rd] = max.
  - `stall_o` = `issue_valid_i` & (raw1 | raw2 | full) & ~`flush_i`.
- Counter update per register r≠0, each cycle:
  - inc = `issue_fire_o` & `rd_wen_i` & rd=r; dec = `wb_valid_i` & wb_addr=r & counter[r]≠0.
  - inc&dec → unchanged; inc only → +1; dec only → −1.
  - Write-back to r with counter 0 (r≠0): counter stays 0, `wb_err_o` set.
  - Write-back or issue targeting x0: ignored, no error.
- `flush_i`: next cycle all counters 0; overrides same-cycle issue and write-back; `wb_err_o` and `stall_cnt_o` are not cleared by flush.
- `stall_cnt_o` increments each cycle `issue_valid_i & stall_o`, saturates at all-ones.
- WAW allowed: multiple writes to same rd in flight up to counter max; register stays pending until all retire.

## Timing
- Reset (asynchronous assert, synchronous-edge release): counters 0, `pending_o`=0, `busy_o`=0, `wb_err_o`=0, `stall_cnt_o`=0; `stall_o`/`issue_fire_o` follow inputs combinationally (no stall with counters 0).
- Issue accepted in cycle N with rd=r → `pending_o[r]`=1 from N+1; dependent instruction stalls from N+1.
- Write-back of last outstanding write to r in cycle M → `pending_o[r]`=0 and dependents issue in M+1 (one-cycle bubble; matches synchronous regfile write).
- Reset asserted mid-operation: all state cleared immediately, regardless of clock.
- `stall_o` has no registered latency; `pending_o`, `busy_o`, `wb_err_o`, `stall_cnt_o` are registered.

## Test plan
- Reset: `rst_i`=0 asynchronously mid-cycle with x3 pending → `pending_o`=0, `busy_o`=0, `stall_cnt_o`=0 before next edge.
- RAW: issue rd=5 at N; at N+1 present rs1=5 used → `stall_o`=1; `wb_valid_i`, `wb_addr_i`=5 at N+3 → `stall_o`=0 at N+4, `stall_cnt_o`=3.
- x0 and unused sources: issue rd=0 → `pending_o`=0; rs2=7 with `rs2_used_i`=0 while x7 pending → `stall_o`=0.
- WAW saturation: three issues rd=9 → counter 3; fourth rd=9 stalls (full); one write-back → `pending_o[9]` still 1, fourth issues next cycle.
- Simultaneous: issue rd=4 and write-back x4 same cycle with counter 1 → counter stays 1; write-back to x6 with counter 0 → `wb_err_o`=1, sticky.
- Flush: x2,x8 pending, `flush_i`=1 with concurrent issue rd=10 → next cycle `pending_o`=0, `busy_o`=0, `stall_cnt_o` unchanged.
